// File: rtl/video_timing_monitor_if.sv
// Pixel stream bundle: 24-bit rgb with data-enable, skip qualifier and sync strobes.
// The generator drives the master side and monitors attach through the slave side.
interface video_if;
    logic [23:0] rgb;
    logic        de;
    logic        skip;
    logic        vs;
    logic        hs;

    modport master (output rgb, de, skip, vs, hs);
    modport slave  (input  rgb, de, skip, vs, hs);
endinterface

// File: rtl/video_timing_monitor.sv
// Frame timing monitor for a video_if stream: measures totals, the active window,
// sync-to-active offsets and a pixel checksum, and publishes them on every vs rise.
module video_timing_monitor #(
    parameter int CW    = 12,
    parameter int SUM_W = 32
) (
    input  logic             rgb_clock,
    input  logic             reset,
    video_if.slave           video,
    output logic [CW-1:0]    h_total,
    output logic [CW-1:0]    v_total,
    output logic [CW-1:0]    h_active,
    output logic [CW-1:0]    v_active,
    output logic [CW-1:0]    h_start,
    output logic [CW-1:0]    v_start,
    output logic [SUM_W-1:0] checksum,
    output logic             frame_done,
    output logic             locked,
    output logic             width_err,
    output logic             overflow
);
    localparam logic [CW-1:0] MAX = '1;

    typedef enum logic [1:0] {SEARCH, MEASURE, RUN} state_t;
    state_t state, state_next;

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (v == MAX) ? MAX : v + CW'(1);
    endfunction

    logic [23:0]      rgb_p0;
    logic             de_p0, skip_p0, vs_p0, hs_p0, vs_p1, hs_p1;
    logic [CW-1:0]    hcnt_q, line_total_q, line_idx_q, pix_cnt_q;
    logic [CW-1:0]    v_active_q, h_active_q, hst_q, vst_q;
    logic             hs_seen_q, line_act_q, have_ha_q, err_q, first_q, ovf_q;
    logic [SUM_W-1:0] sum_q;

    logic             hs_rise, vs_rise, line_end, pix, publish, compare;
    logic             hcnt_sat, pix_sat, idx_sat, va_sat, ovf_pub;
    logic [CW-1:0]    hcnt_cur, idx_base, idx_cur, pix_base, pix_next;
    logic [CW-1:0]    close_va, close_ha, hst_next, vst_next;
    logic             close_have, close_err, act_next, first_next;
    logic [SUM_W-1:0] sum_next;

    // Stage p0 -> p1: edge detection and per-cycle accumulation on the registered inputs
    always_comb begin
        hs_rise  = hs_p0 & ~hs_p1;
        vs_rise  = vs_p0 & ~vs_p1;
        line_end = hs_rise | vs_rise;
        pix      = de_p0 & ~skip_p0;
        hcnt_sat = (hcnt_q == MAX);
        hcnt_cur = hs_rise ? '0 : sat_inc(hcnt_q);

        // A closing line contributes to the frame it belongs to, even on a vs-rise cycle
        close_va   = v_active_q;
        close_ha   = h_active_q;
        close_have = have_ha_q;
        close_err  = err_q;
        va_sat     = 1'b0;
        if (line_end && line_act_q) begin
            if (!have_ha_q) begin
                close_ha   = pix_cnt_q;
                close_have = 1'b1;
            end else if (pix_cnt_q != h_active_q) begin
                close_err = 1'b1;
            end
            close_va = sat_inc(v_active_q);
            va_sat   = (v_active_q == MAX);
        end
        ovf_pub = ovf_q | va_sat;

        pix_base = line_end ? '0 : pix_cnt_q;
        pix_sat  = pix && (pix_base == MAX);
        pix_next = pix ? sat_inc(pix_base) : pix_base;
        act_next = (line_act_q && !line_end) || de_p0;

        idx_base = vs_rise ? '0 : line_idx_q;
        idx_sat  = hs_rise && (idx_base == MAX);
        idx_cur  = hs_rise ? sat_inc(idx_base) : idx_base;

        first_next = first_q && !vs_rise;
        hst_next   = vs_rise ? '0 : hst_q;
        vst_next   = vs_rise ? '0 : vst_q;
        if (de_p0 && !first_next) begin
            first_next = 1'b1;
            hst_next   = hcnt_cur;
            vst_next   = idx_cur;
        end

        sum_next = vs_rise ? '0 : sum_q;
        if (pix)
            sum_next = sum_next + SUM_W'(rgb_p0);
    end

    always_comb begin
        state_next = state;
        publish    = 1'b0;
        compare    = 1'b0;
        unique case (state)
            SEARCH:  if (vs_rise) state_next = MEASURE;
            MEASURE: if (vs_rise) begin
                publish    = 1'b1;
                state_next = RUN;
            end
            RUN: begin
                publish = vs_rise;
                compare = vs_rise;
            end
            default: state_next = SEARCH;
        endcase
    end

    always_ff @(posedge rgb_clock) begin
        if (reset) state <= SEARCH;
        else       state <= state_next;
    end

    // Stage wire -> p0 input capture, then p1 accumulators and published outputs
    always_ff @(posedge rgb_clock) begin
        rgb_p0 <= video.rgb;
        if (reset) begin
            de_p0 <= 1'b0; skip_p0 <= 1'b0; vs_p0 <= 1'b0; hs_p0 <= 1'b0;
            vs_p1 <= 1'b0; hs_p1 <= 1'b0;
            hcnt_q <= '0; line_total_q <= '0; line_idx_q <= '0; pix_cnt_q <= '0;
            v_active_q <= '0; h_active_q <= '0; hst_q <= '0; vst_q <= '0;
            hs_seen_q <= 1'b0; line_act_q <= 1'b0; have_ha_q <= 1'b0;
            err_q <= 1'b0; first_q <= 1'b0; ovf_q <= 1'b0; sum_q <= '0;
            h_total <= '0; v_total <= '0; h_active <= '0; v_active <= '0;
            h_start <= '0; v_start <= '0; checksum <= '0;
            frame_done <= 1'b0; locked <= 1'b0; width_err <= 1'b0; overflow <= 1'b0;
        end else begin
            de_p0 <= video.de; skip_p0 <= video.skip;
            vs_p0 <= video.vs; hs_p0 <= video.hs;
            vs_p1 <= vs_p0;    hs_p1 <= hs_p0;

            hcnt_q    <= hcnt_cur;
            hs_seen_q <= hs_seen_q | hs_rise;
            if (hs_rise && hs_seen_q)
                line_total_q <= sat_inc(hcnt_q);
            line_idx_q <= idx_cur;
            pix_cnt_q  <= pix_next;
            line_act_q <= act_next;

            v_active_q <= vs_rise ? '0   : close_va;
            h_active_q <= vs_rise ? '0   : close_ha;
            have_ha_q  <= vs_rise ? 1'b0 : close_have;
            err_q      <= vs_rise ? 1'b0 : close_err;
            first_q    <= first_next;
            hst_q      <= hst_next;
            vst_q      <= vst_next;
            sum_q      <= sum_next;
            ovf_q      <= (vs_rise ? 1'b0 : ovf_pub) | hcnt_sat | pix_sat | idx_sat;

            frame_done <= publish;
            if (publish) begin
                h_total   <= line_total_q;
                v_total   <= line_idx_q;
                h_active  <= close_have ? close_ha : '0;
                v_active  <= close_va;
                h_start   <= first_q ? hst_q : '0;
                v_start   <= first_q ? vst_q : '0;
                checksum  <= sum_q;
                width_err <= close_err;
                overflow  <= ovf_pub;
                locked    <= compare && (line_total_q == h_total) && (line_idx_q == v_total);
            end
        end
    end
endmodule
